// File: rtl/store_buffer_pkg.sv
// Shared constants, entry layout and flush states
// for the data-side store buffer.
package store_buffer_pkg;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int MEM_AW = 3;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sb_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } sb_state_e;

endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-match store-to-load forwarding lookup
// over the circular store buffer.
module sb_fwd_match
  import store_buffer_pkg::*;
(
  input  sb_entry_t         entries_i [DEPTH],
  input  logic [DEPTH-1:0]  valid_i,
  input  logic [PTR_W-1:0]  head_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              hit_o,
  output logic [DATA_W-1:0] data_o
);

  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_i + PTR_W'(k);
      if (valid_i[idx] &&
          entries_i[idx].addr[MEM_AW-1:0] ==
          addr_i[MEM_AW-1:0]) begin
        hit_o  = 1'b1;
        data_o = entries_i[idx].data;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Store buffer between the memory-access stage and
// data memory: queues stores, forwards loads, drains.
module store_buffer
  import store_buffer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              flush_req,
  output logic              flush_done,
  output logic [CNT_W-1:0]  sb_count,
  output logic [ADDR_W-1:0] mem_access_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_en,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data
);

  sb_state_e         state_q, state_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  sb_entry_t         entries_q [DEPTH];
  sb_entry_t         entries_d [DEPTH];
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic              accept;
  logic              st_acc;
  logic              ld_acc;
  logic              drain;
  logic              full;
  logic [DEPTH-1:0]  valid;
  logic [PTR_W-1:0]  off;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  sb_fwd_match u_fwd (
    .entries_i (entries_q),
    .valid_i   (valid),
    .head_i    (head_q),
    .addr_i    (req_addr),
    .hit_o     (fwd_hit),
    .data_o    (fwd_data)
  );

  assign full      = (count_q == CNT_W'(DEPTH));
  assign req_ready = !rst && (state_q == IDLE) && !full;
  assign accept    = req_valid && req_ready;
  assign st_acc    = accept && req_write;
  assign ld_acc    = accept && !req_write;
  // An accepted request owns the memory port.
  assign drain     = !rst && (count_q != '0) && !accept;

  always_comb begin
    valid = '0;
    off   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off      = PTR_W'(i) - head_q;
      valid[i] = CNT_W'(off) < count_q;
    end
  end

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    if (st_acc) begin
      entries_d[tail_q] = '{addr: req_addr, data: req_wdata};
      tail_d  = tail_q + PTR_W'(1);
      count_d = count_q + CNT_W'(1);
    end else if (drain) begin
      head_d  = head_q + PTR_W'(1);
      count_d = count_q - CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (flush_req) state_d = FLUSH;
      FLUSH:   if (count_d == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rsp_valid_d = ld_acc;
    rsp_rdata_d = rsp_rdata_q;
    if (ld_acc) begin
      rsp_rdata_d = fwd_hit ? fwd_data : mem_read_data;
    end
  end

  always_comb begin
    mem_access_addr = '0;
    mem_write_data  = '0;
    mem_write_en    = 1'b0;
    mem_read        = 1'b0;
    if (ld_acc && !fwd_hit) begin
      mem_access_addr = req_addr;
      mem_read        = 1'b1;
    end else if (drain) begin
      mem_access_addr = entries_q[head_q].addr;
      mem_write_data  = entries_q[head_q].data;
      mem_write_en    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= entries_d[i];
      end
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign sb_count   = count_q;
  assign flush_done = (state_q == DONE);

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a small
// data memory model and table-driven vectors.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        req_ready;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        flush_req = 1'b0;
  logic        flush_done;
  logic [2:0]  sb_count;
  logic [15:0] mem_access_addr;
  logic [15:0] mem_write_data;
  logic        mem_write_en;
  logic        mem_read;
  logic [15:0] mem_read_data;

  logic [15:0] mem [8] = '{
    16'h0100, 16'h0101, 16'h0102, 16'h0103,
    16'h0104, 16'h0105, 16'h00F0, 16'h0107
  };

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_access_addr[2:0]];

  always @(posedge clk) begin
    if (mem_write_en) mem[mem_access_addr[2:0]] <= mem_write_data;
  end

  store_buffer dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_write       (req_write),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .req_ready       (req_ready),
    .rsp_valid       (rsp_valid),
    .rsp_rdata       (rsp_rdata),
    .flush_req       (flush_req),
    .flush_done      (flush_done),
    .sb_count        (sb_count),
    .mem_access_addr (mem_access_addr),
    .mem_write_data  (mem_write_data),
    .mem_write_en    (mem_write_en),
    .mem_read        (mem_read),
    .mem_read_data   (mem_read_data)
  );

  typedef struct {
    logic        v;
    logic        w;
    logic [15:0] a;
    logic [15:0] d;
    logic        rdy;
    logic        we;
    logic        rd;
    logic [15:0] ma;
    logic [15:0] md;
    logic        rv;
    logic [15:0] rr;
    logic [2:0]  cnt;
  } row_t;

  row_t rows [$];

  function automatic row_t mk(
    input logic v, w,
    input logic [15:0] a, d,
    input logic rdy, we, rd,
    input logic [15:0] ma, md,
    input logic rv,
    input logic [15:0] rr,
    input logic [2:0] cnt
  );
    row_t r;
    r = '{v, w, a, d, rdy, we, rd, ma, md, rv, rr, cnt};
    return r;
  endfunction

  task automatic chk(
    input string nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(
    input logic v, w,
    input logic [15:0] a, d,
    input logic fl
  );
    req_valid = v;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    flush_req = fl;
  endtask

  task automatic cyc(
    input logic v, w,
    input logic [15:0] a, d,
    input logic fl
  );
    @(negedge clk);
    drive(v, w, a, d, fl);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Idle, store, forward, miss, full, wrap, store-then-load.
    rows.push_back(mk(1,1,16'd3,16'h1234, 1,0,0,16'd0,16'h0000, 0,16'h0000,3'd1));
    rows.push_back(mk(0,0,16'd0,16'h0000, 1,1,0,16'd3,16'h1234, 0,16'h0000,3'd0));
    rows.push_back(mk(1,1,16'd5,16'hAAAA, 1,0,0,16'd0,16'h0000, 0,16'h0000,3'd1));
    rows.push_back(mk(1,1,16'd5,16'hBBBB, 1,0,0,16'd0,16'h0000, 0,16'h0000,3'd2));
    rows.push_back(mk(1,0,16'd13,16'h0000,1,0,0,16'd0,16'h0000, 1,16'hBBBB,3'd2));
    rows.push_back(mk(0,0,16'd0,16'h0000, 1,1,0,16'd5,16'hAAAA, 0,16'hBBBB,3'd1));
    rows.push_back(mk(0,0,16'd0,16'h0000, 1,1,0,16'd5,16'hBBBB, 0,16'hBBBB,3'd0));
    rows.push_back(mk(1,0,16'd6,16'h0000, 1,0,1,16'd6,16'h0000, 1,16'h00F0,3'd0));
    rows.push_back(mk(1,0,16'd5,16'h0000, 1,0,1,16'd5,16'h0000, 1,16'hBBBB,3'd0));
    rows.push_back(mk(1,0,16'd3,16'h0000, 1,0,1,16'd3,16'h0000, 1,16'h1234,3'd0));
    rows.push_back(mk(1,1,16'd0,16'h1000, 1,0,0,16'd0,16'h0000, 0,16'h1234,3'd1));
    rows.push_back(mk(1,1,16'd1,16'h1001, 1,0,0,16'd0,16'h0000, 0,16'h1234,3'd2));
    rows.push_back(mk(1,1,16'd2,16'h1002, 1,0,0,16'd0,16'h0000, 0,16'h1234,3'd3));
    rows.push_back(mk(1,1,16'd3,16'h1003, 1,0,0,16'd0,16'h0000, 0,16'h1234,3'd4));
    rows.push_back(mk(1,1,16'd4,16'h1004, 0,1,0,16'd0,16'h1000, 0,16'h1234,3'd3));
    rows.push_back(mk(1,1,16'd4,16'h1004, 1,0,0,16'd0,16'h0000, 0,16'h1234,3'd4));
    rows.push_back(mk(1,0,16'd10,16'h0000,0,1,0,16'd1,16'h1001, 0,16'h1234,3'd3));
    rows.push_back(mk(1,0,16'd10,16'h0000,1,0,0,16'd0,16'h0000, 1,16'h1002,3'd3));
    rows.push_back(mk(0,0,16'd0,16'h0000, 1,1,0,16'd2,16'h1002, 0,16'h1002,3'd2));
    rows.push_back(mk(0,0,16'd0,16'h0000, 1,1,0,16'd3,16'h1003, 0,16'h1002,3'd1));
    rows.push_back(mk(0,0,16'd0,16'h0000, 1,1,0,16'd4,16'h1004, 0,16'h1002,3'd0));
    rows.push_back(mk(1,1,16'd7,16'h7777, 1,0,0,16'd0,16'h0000, 0,16'h1002,3'd1));
    rows.push_back(mk(1,0,16'd7,16'h0000, 1,0,0,16'd0,16'h0000, 1,16'h7777,3'd1));
    rows.push_back(mk(0,0,16'd0,16'h0000, 1,1,0,16'd7,16'h7777, 0,16'h7777,3'd0));

    // Reset state while rst is held.
    @(negedge clk);
    #1;
    chk("reset count", 64'(sb_count), 64'd0);
    chk("reset rsp", 64'({rsp_valid, rsp_rdata}), 64'd0);
    chk("reset mem", 64'({mem_write_en, mem_read, mem_access_addr}), 64'd0);
    chk("reset ready_done", 64'({req_ready, flush_done}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (rows[i]) begin
      @(negedge clk);
      drive(rows[i].v, rows[i].w, rows[i].a, rows[i].d, 1'b0);
      #1;
      chk($sformatf("row%0d pre", i),
          64'({req_ready, mem_write_en, mem_read, flush_done,
               mem_access_addr, mem_write_data}),
          64'({rows[i].rdy, rows[i].we, rows[i].rd, 1'b0,
               rows[i].ma, rows[i].md}));
      @(posedge clk);
      #1;
      chk($sformatf("row%0d post", i),
          64'({rsp_valid, rsp_rdata, sb_count}),
          64'({rows[i].rv, rows[i].rr, rows[i].cnt}));
    end
    chk("mem after drains",
        {mem[0], mem[1], mem[2], mem[7]},
        {16'h1000, 16'h1001, 16'h1002, 16'h7777});

    // Flush with three buffered stores.
    cyc(1, 1, 16'd1, 16'h0011, 0);
    cyc(1, 1, 16'd2, 16'h0022, 0);
    cyc(1, 1, 16'd3, 16'h0033, 0);
    chk("flush fill", 64'(sb_count), 64'd3);
    @(negedge clk);
    drive(0, 0, 16'd0, 16'd0, 1);
    #1;
    chk("flush c0", 64'({req_ready, mem_write_en, flush_done, mem_access_addr}),
        64'({1'b1, 1'b1, 1'b0, 16'd1}));
    for (int k = 2; k <= 3; k++) begin
      @(negedge clk);
      drive(1, 1, 16'd6, 16'h6666, 0);
      #1;
      chk($sformatf("flush c%0d", k - 1),
          64'({req_ready, mem_write_en, flush_done, mem_access_addr}),
          64'({1'b0, 1'b1, 1'b0, 16'(k)}));
    end
    @(negedge clk);
    drive(0, 0, 16'd0, 16'd0, 0);
    #1;
    chk("flush done", 64'({req_ready, mem_write_en, flush_done, sb_count}),
        64'({1'b0, 1'b0, 1'b1, 3'd0}));
    @(negedge clk);
    #1;
    chk("flush idle", 64'({req_ready, flush_done}), 64'({1'b1, 1'b0}));
    chk("flush mem", {mem[1], mem[2], mem[3], mem[6]},
        {16'h0011, 16'h0022, 16'h0033, 16'h00F0});

    // Flush of an empty buffer completes two cycles later.
    @(negedge clk);
    drive(0, 0, 16'd0, 16'd0, 1);
    #1;
    chk("eflush c0", 64'(flush_done), 64'd0);
    @(negedge clk);
    drive(0, 0, 16'd0, 16'd0, 0);
    #1;
    chk("eflush c1", 64'({flush_done, req_ready}), 64'd0);
    @(negedge clk);
    #1;
    chk("eflush c2", 64'(flush_done), 64'd1);
    @(negedge clk);
    #1;
    chk("eflush c3", 64'({flush_done, req_ready}), 64'b01);

    // Reset mid-operation discards buffered stores.
    cyc(1, 1, 16'd0, 16'hDEAD, 0);
    cyc(1, 1, 16'd1, 16'hBEEF, 0);
    cyc(1, 0, 16'd8, 16'h0000, 0);
    chk("pre-rst rsp", 64'({rsp_valid, rsp_rdata, sb_count}),
        64'({1'b1, 16'hDEAD, 3'd2}));
    @(negedge clk);
    drive(0, 0, 16'd0, 16'd0, 0);
    rst = 1'b1;
    #1;
    chk("rst async", 64'({sb_count, mem_write_en, rsp_valid, req_ready}),
        64'd0);
    @(negedge clk);
    #1;
    chk("rst hold", 64'({mem_write_en, mem_read}), 64'd0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("post-rst idle", 64'({mem_write_en, sb_count}), 64'd0);
    end
    chk("post-rst mem", {mem[0], mem[1]}, {16'h1000, 16'h0011});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
